// File: rtl/fifo_wr_frontend_if.sv
// Stream and FIFO write-side bus for fifo_wr_frontend.
// master: the surrounding environment (upstream producer plus pointer logic).
// slave:  the write front end itself.
interface fifo_wr_frontend_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             s_valid;
    logic [DSIZE-1:0] s_data;
    logic             s_ready;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   wq2_rptr;
    logic [ASIZE:0]   wlevel;
    logic             walmost_full;

    modport master (
        output s_valid, s_data, wfull, wptr, wq2_rptr,
        input  s_ready, winc, wdata, wlevel, walmost_full
    );

    modport slave (
        input  s_valid, s_data, wfull, wptr, wq2_rptr,
        output s_ready, winc, wdata, wlevel, walmost_full
    );
endinterface

// File: rtl/fifo_wr_frontend.sv
// Write-domain ingress stage of the async FIFO.
// A 2-entry skid buffer turns the upstream valid/ready stream into winc/wdata
// with fully registered backpressure (s_ready depends only on buffer state),
// and a registered fill level / almost-full flag is derived from the Gray
// write pointer and the synchronized Gray read pointer.
// Optional build macro FIFO_WR_STATS_EN adds saturating write/stall counters.
module fifo_wr_frontend #(
    parameter int DSIZE        = 8,
    parameter int ASIZE        = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_wr_frontend_if.slave    bus
`ifdef FIFO_WR_STATS_EN
    ,
    output logic [15:0]          stat_wr_cnt,
    output logic [15:0]          stat_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [ASIZE:0] AFULL_V = (ASIZE+1)'(AFULL_THRESH);

    state_t           state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic [ASIZE:0]   wlevel_q;
    logic             walmost_full_q;
    logic [ASIZE:0]   diff;
    logic             s_ready_c;
    logic             winc_c;
    logic             acc;
    logic             drn;

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b = '0;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign acc = bus.s_valid & s_ready_c;
    assign drn = winc_c;

    // Skid buffer occupancy state register.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    // Occupancy next state: cnt + acc - drn.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (acc) state_d = ONE;
            ONE: begin
                if (acc && !drn)      state_d = TWO;
                else if (!acc && drn) state_d = EMPTY;
            end
            TWO:     if (drn) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs decoded from registered state; wfull only gates winc.
    always_comb begin
        s_ready_c = (state_q != TWO);
        winc_c    = (state_q != EMPTY) && !bus.wfull;
    end

    // Data steering: head holds the next word to write, skid the one behind it.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (drn && state_q == TWO) begin
            head_d = skid_q;
        end else if (acc && (state_q == EMPTY || (state_q == ONE && drn))) begin
            head_d = bus.s_data;
        end
        if (acc && state_q == ONE && !drn) begin
            skid_d = bus.s_data;
        end
    end

    // Data registers; cleared on reset so stale words never reappear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    // Modulo pointer difference; wraps correctly across the extra MSB.
    always_comb begin
        diff = gray2bin(bus.wptr) - gray2bin(bus.wq2_rptr);
    end

    // Registered level and almost-full, both from the same difference.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
        end else begin
            wlevel_q       <= diff;
            walmost_full_q <= (diff >= AFULL_V);
        end
    end

    assign bus.s_ready      = s_ready_c;
    assign bus.winc         = winc_c;
    assign bus.wdata        = head_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.walmost_full = walmost_full_q;

`ifdef FIFO_WR_STATS_EN
    logic [15:0] stat_wr_q;
    logic [15:0] stat_stall_q;

    // Saturating counters of write cycles and of cycles held off by wfull.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (winc_c && stat_wr_q != 16'hFFFF) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end
            if (state_q != EMPTY && bus.wfull && stat_stall_q != 16'hFFFF) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign stat_wr_cnt    = stat_wr_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Testbench for fifo_wr_frontend: table-driven handshake vectors, a level
// table, and hand-written reset and (optionally) statistics sequences.
module tb_fifo_wr_frontend;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;

    logic wclk;
    logic wrst_n;
    int   total;
    int   bad;

    fifo_wr_frontend_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

`ifdef FIFO_WR_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    fifo_wr_frontend #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_THRESH(12)) dut (
        .wclk           (wclk),
        .wrst_n         (wrst_n),
        .bus            (bus.slave)
`ifdef FIFO_WR_STATS_EN
        ,
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       full;
        logic       rdy;
        logic       winc;
        logic [7:0] wdata;
    } vec_t;

    typedef struct packed {
        logic [5:0] wp;
        logic [5:0] rp;
        logic [4:0] lvl;
        logic       af;
    } lvl_t;

    vec_t vt[27];
    lvl_t lt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] gray(input logic [5:0] x);
        logic [4:0] b;
        b = x[4:0];
        return b ^ (b >> 1);
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // {s_valid, s_data, wfull, exp s_ready, exp winc, exp wdata}
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        for (int k = 1; k <= 10; k++) begin
            vt[k] = '{1'b1, 8'(k - 1), 1'b0, 1'b1, (k >= 2), (k >= 2) ? 8'(k - 2) : 8'h00};
        end
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h09};
        vt[13] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h09};
        vt[14] = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'hA0};
        vt[15] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'hA0};
        vt[16] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'hA0};
        vt[17] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0};
        vt[18] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2};
        vt[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA2};
        vt[21] = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 8'hA2};
        vt[22] = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 8'hB0};
        vt[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB0};
        vt[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB0};
        vt[25] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB1};
        vt[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hB1};

        // {wptr bin, rptr bin, exp wlevel, exp walmost_full}
        lt[0] = '{6'd3,  6'd30, 5'd5,  1'b0};
        lt[1] = '{6'd10, 6'd30, 5'd12, 1'b1};
        lt[2] = '{6'd0,  6'd0,  5'd0,  1'b0};
        lt[3] = '{6'd11, 6'd0,  5'd11, 1'b0};
        lt[4] = '{6'd5,  6'd21, 5'd16, 1'b1};
        lt[5] = '{6'd31, 6'd31, 5'd0,  1'b0};
        lt[6] = '{6'd16, 6'd0,  5'd16, 1'b1};

        wrst_n       = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.wfull    = 1'b0;
        bus.wptr     = '0;
        bus.wq2_rptr = '0;
        repeat (2) @(negedge wclk);
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_winc",    32'(bus.winc), 32'd0);
        check("rst_wlevel",  32'(bus.wlevel), 32'd0);
        check("rst_afull",   32'(bus.walmost_full), 32'd0);
        wrst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge wclk);
            bus.s_valid = vt[i].v;
            bus.s_data  = vt[i].d;
            bus.wfull   = vt[i].full;
            #1;
            check($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(vt[i].rdy));
            check($sformatf("vec%0d_winc", i),    32'(bus.winc),    32'(vt[i].winc));
            check($sformatf("vec%0d_wdata", i),   32'(bus.wdata),   32'(vt[i].wdata));
        end

        for (int i = 0; i < 7; i++) begin
            @(negedge wclk);
            bus.wptr     = gray(lt[i].wp);
            bus.wq2_rptr = gray(lt[i].rp);
            @(negedge wclk);
            #1;
            check($sformatf("lvl%0d_wlevel", i), 32'(bus.wlevel), 32'(lt[i].lvl));
            check($sformatf("lvl%0d_afull", i),  32'(bus.walmost_full), 32'(lt[i].af));
        end

        // Reset while two words are held and the level reads full.
        @(negedge wclk);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC0;
        bus.wfull   = 1'b1;
        @(negedge wclk);
        bus.s_data  = 8'hC1;
        @(negedge wclk);
        #1;
        check("pre_rst_s_ready", 32'(bus.s_ready), 32'd0);
        bus.s_valid = 1'b0;
        bus.wfull   = 1'b0;
        #1;
        check("pre_rst_winc", 32'(bus.winc), 32'd1);
        wrst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("mid_rst_winc",    32'(bus.winc), 32'd0);
        check("mid_rst_wdata",   32'(bus.wdata), 32'd0);
        check("mid_rst_wlevel",  32'(bus.wlevel), 32'd0);
        check("mid_rst_afull",   32'(bus.walmost_full), 32'd0);
        bus.wptr     = '0;
        bus.wq2_rptr = '0;
        @(negedge wclk);
        wrst_n      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hD0;
        @(negedge wclk);
        bus.s_valid = 1'b0;
        #1;
        check("post_rst_winc",  32'(bus.winc), 32'd1);
        check("post_rst_wdata", 32'(bus.wdata), 32'hD0);
        @(negedge wclk);
        #1;
        check("post_rst_idle", 32'(bus.winc), 32'd0);

`ifdef FIFO_WR_STATS_EN
        wrst_n = 1'b0;
        #1;
        check("stat_rst_wr", 32'(stat_wr_cnt), 32'd0);
        wrst_n = 1'b1;
        @(negedge wclk);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        bus.wfull   = 1'b1;
        repeat (7) begin
            @(negedge wclk);
            bus.s_valid = 1'b0;
        end
        for (int i = 0; i < 19; i++) begin
            @(negedge wclk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i);
            bus.wfull   = 1'b0;
        end
        @(negedge wclk);
        bus.s_valid = 1'b0;
        @(negedge wclk);
        #1;
        check("stat_wr_20",   32'(stat_wr_cnt), 32'd20);
        check("stat_stall_7", 32'(stat_stall_cnt), 32'd7);
        bus.s_valid = 1'b1;
        repeat (65535) @(negedge wclk);
        #1;
        check("stat_wr_sat",      32'(stat_wr_cnt), 32'hFFFF);
        check("stat_stall_still", 32'(stat_stall_cnt), 32'd7);
        bus.s_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
